mcpu_vram_dma: RTL
==================

MCPU_VRAM_DMA -- requirements
Module: mcpu_vram_dma

Interface
REQ-001 Parameter AW, default 13, VRAM address width (8 KB VRAM).
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready at posedge.
REQ-006 cmd_op  in  2  operation: 00 fill, 01 copy, 10 masked fill, 11 reserved.
REQ-007 cmd_src  in  AW  copy source start address.
REQ-008 cmd_dst  in  AW  destination start address.
REQ-009 cmd_len  in  AW  byte count; 0 means no transfer.
REQ-010 cmd_fill  in  8  fill byte (ops 00, 10).
REQ-011 cmd_mask  in  8  bit mask (op 10).
REQ-012 cpu_addr / cpu_we / cpu_wdata  in  AW/1/8  CPU VRAM access, passed through when idle.
REQ-013 cpu_stall  out  1  high whenever state != IDLE.
REQ-014 busy  out  1  high whenever state != IDLE.
REQ-015 done  out  1  one-cycle pulse on command completion.
REQ-016 err  out  1  sticky; set on reserved op, cleared on next accepted valid command.
REQ-017 vram_addr / vram_we / vram_wdata  out  AW/1/8  drives the GPU VRAM port.
REQ-018 vram_rdata  in  8  GPU VRAM read data, combinational from vram_addr (same cycle).

Function
REQ-019 States: IDLE, FILL, RD, WR, DONE; encoding free.
REQ-020 IDLE: vram_addr=cpu_addr, vram_we=cpu_we, vram_wdata=cpu_wdata (combinational pass-through).
REQ-021 Non-IDLE: CPU inputs are ignored; cpu writes during busy are dropped, not queued.
REQ-022 On accept: latch src, dst, remaining=cmd_len, fill, mask, op.
REQ-023 Accept with cmd_len==0 or op==11: next state DONE, no VRAM write; op 11 sets err.
REQ-024 Op 00: FILL each cycle: vram_addr=dst, vram_we=1, vram_wdata=fill; dst+=1, remaining-=1; remaining reaching 0 -> DONE. Throughput 1 byte/cycle.
REQ-025 Op 01: RD: vram_addr=src, vram_we=0, latch vram_rdata; WR: vram_addr=dst, vram_we=1, vram_wdata=latched byte; src,dst +=1, remaining-=1; WR -> RD, or DONE when remaining reaches 0. 2 cycles/byte.
REQ-026 Op 10: RD at dst latches old byte; WR writes (old & ~mask) | (fill & mask); 2 cycles/byte.
REQ-027 Copy is strictly ascending; overlapping regions with dst>src replicate source bytes; this behaviour is defined, not an error.
REQ-028 Address arithmetic modulo 2^AW: 8191+1 wraps to 0.
REQ-029 DONE: done=1, vram_we=0, busy=1 for exactly that cycle; next state IDLE.
REQ-030 cmd_ready=0 during DONE; the earliest next accept is the first IDLE cycle.
REQ-031 Latency from accept to done pulse: fill len+1 cycles, copy/masked 2*len+1 cycles, len==0 1 cycle.
REQ-032 vram_we is never asserted in RD or DONE.
REQ-033 Writes into the GPU control-register addresses (8187-8191) are treated as ordinary writes.

Reset
REQ-034 On reset: state=IDLE, busy=0, done=0, err=0, cmd_ready=1, cpu_stall=0, internal counters/latches=0.
REQ-035 Reset mid-operation aborts immediately; no write occurs in the reset cycle; no done pulse; already written bytes are kept.

Verification
REQ-036 Fill dst=0x100, len=4, fill=0xAA -> writes 0x100..0x103=0xAA on 4 consecutive cycles; done on cycle 5 after accept.
REQ-037 Copy src=0x000 (0x11,0x22,0x33), dst=0x010, len=3 -> 0x010..0x012=0x11,0x22,0x33; done 7 cycles after accept.
REQ-038 Masked fill dst=0x20 (old 0xF0), fill=0x0F, mask=0x3C -> 0x20 becomes 0xCC.
REQ-039 Fill dst=8190, len=4, fill=0x55 -> writes to 8190, 8191, 0, 1; no access outside the range.
REQ-040 Reserved op or len=0 -> done one cycle after accept, no vram_we; err=1 only for op 11, cleared by the next valid command.
REQ-041 Assert reset two cycles into fill len=10; cpu_we during busy -> exactly 2 bytes written; no done; CPU write dropped; idle outputs next cycle.

Source files
------------

// File: rtl/mcpu_vram_dma.sv
// rtl/mcpu_vram_dma.sv - VRAM fill/copy/masked-fill DMA engine with CPU pass-through
module mcpu_vram_dma #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_len,
    input  logic [7:0]    cmd_fill,
    input  logic [7:0]    cmd_mask,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_stall,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] vram_addr,
    output logic          vram_we,
    output logic [7:0]    vram_wdata,
    input  logic [7:0]    vram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [7:0]    fill_q, fill_d;
    logic [7:0]    mask_q, mask_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    op_q, op_d;
    logic          err_q, err_d;
    logic          accept;
    logic          last_byte;

    assign accept    = (state_q == S_IDLE) && cmd_valid;
    assign last_byte = (rem_q == AW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latches, address/length counters and the read-back byte
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            fill_q <= '0;
            mask_q <= '0;
            data_q <= '0;
            op_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            rem_q  <= rem_d;
            fill_q <= fill_d;
            mask_q <= mask_d;
            data_q <= data_d;
            op_q   <= op_d;
            err_q  <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0 || cmd_op == OP_RSVD) state_d = S_DONE;
                    else if (cmd_op == OP_FILL)             state_d = S_FILL;
                    else                                    state_d = S_RD;
                end
            end
            S_FILL:  state_d = last_byte ? S_DONE : S_FILL;
            S_RD:    state_d = S_WR;
            S_WR:    state_d = last_byte ? S_DONE : S_RD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; counters advance only on cycles that write a byte
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        rem_d  = rem_q;
        fill_d = fill_q;
        mask_d = mask_q;
        data_d = data_q;
        op_d   = op_q;
        err_d  = err_q;
        if (accept) begin
            src_d  = cmd_src;
            dst_d  = cmd_dst;
            rem_d  = cmd_len;
            fill_d = cmd_fill;
            mask_d = cmd_mask;
            op_d   = cmd_op;
            err_d  = (cmd_op == OP_RSVD);
        end else begin
            case (state_q)
                S_FILL: begin
                    dst_d = dst_q + AW'(1);
                    rem_d = rem_q - AW'(1);
                end
                S_RD: data_d = vram_rdata;
                S_WR: begin
                    src_d = src_q + AW'(1);
                    dst_d = dst_q + AW'(1);
                    rem_d = rem_q - AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs; a write is suppressed in a reset cycle so an abort never lands a byte
    always_comb begin
        vram_addr  = dst_q;
        vram_we    = 1'b0;
        vram_wdata = fill_q;
        case (state_q)
            S_IDLE: begin
                vram_addr  = cpu_addr;
                vram_we    = cpu_we;
                vram_wdata = cpu_wdata;
            end
            S_FILL: vram_we = 1'b1;
            S_RD:   vram_addr = (op_q == OP_COPY) ? src_q : dst_q;
            S_WR: begin
                vram_we    = 1'b1;
                vram_wdata = (op_q == OP_COPY) ? data_q
                                               : ((data_q & ~mask_q) | (fill_q & mask_q));
            end
            default: ;
        endcase
        if (reset) vram_we = 1'b0;
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        cpu_stall = (state_q != S_IDLE);
        done      = (state_q == S_DONE) && !reset;
        err       = err_q;
    end

endmodule
